// File: rtl/rca_share_arbiter_if.sv
// Requester-side bus of the shared-adder arbiter: requests, operands, grants and tagged results.
interface rca_share_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDW   = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a;
    logic [NREQ*WIDTH-1:0] op_b;
    logic [NREQ-1:0]       op_c;
    logic [NREQ-1:0]       gnt;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;

    modport master (
        output req, op_a, op_b, op_c,
        input  gnt, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

    modport slave (
        input  req, op_a, op_b, op_c,
        output gnt, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
endinterface

// File: rtl/rca_share_arbiter.sv
// Round-robin arbiter sharing one external pipelined adder among NREQ requesters;
// results return tagged with the requester ID through a tag pipe matched to the adder latency.
module rca_share_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LAT   = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    rca_share_arbiter_if.slave    bus,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_c,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic [IDW+2:0]        inflight
);

    localparam int unsigned CW = IDW + 3;

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   idx;
    logic [IDW-1:0]   gnt_id;
    logic             gnt_any;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_c;

    // Issue-stage tag travels with the registered operands; the pipe then covers the adder latency.
    logic             iss_v;
    logic [IDW-1:0]   iss_id;
    logic [LAT-1:0]   tag_v;
    logic [IDW-1:0]   tag_id [LAT];

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] p, input int unsigned k);
        return IDW'((32'(p) + k) % NREQ);
    endfunction

    // Round-robin search starting at ptr, wrapping past NREQ-1.
    always_comb begin
        bus.gnt = '0;
        idx     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        sel_a   = '0;
        sel_b   = '0;
        sel_c   = 1'b0;
        if (en && !rst) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = rr_idx(ptr, k);
                if (!gnt_any && bus.req[idx]) begin
                    bus.gnt[idx] = 1'b1;
                    gnt_id       = idx;
                    gnt_any      = 1'b1;
                    sel_a        = bus.op_a[32'(idx)*WIDTH +: WIDTH];
                    sel_b        = bus.op_b[32'(idx)*WIDTH +: WIDTH];
                    sel_c        = bus.op_c[idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= '0;
            add_a         <= '0;
            add_b         <= '0;
            add_c         <= 1'b0;
            iss_v         <= 1'b0;
            iss_id        <= '0;
            tag_v         <= '0;
            for (int unsigned k = 0; k < LAT; k++) begin
                tag_id[k] <= '0;
            end
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_sum   <= '0;
            bus.rsp_cout  <= 1'b0;
            inflight      <= '0;
        end else begin
            if (gnt_any) begin
                ptr <= (32'(gnt_id) == NREQ - 1) ? '0 : gnt_id + IDW'(1);
            end
            add_a  <= sel_a;
            add_b  <= sel_b;
            add_c  <= sel_c;
            iss_v  <= gnt_any;
            iss_id <= gnt_id;

            tag_v[0]  <= iss_v;
            tag_id[0] <= iss_id;
            for (int unsigned k = 1; k < LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end

            bus.rsp_valid <= tag_v[LAT-1];
            bus.rsp_id    <= tag_id[LAT-1];
            if (tag_v[LAT-1]) begin
                bus.rsp_sum  <= add_sum;
                bus.rsp_cout <= add_cout;
            end

            case ({gnt_any, bus.rsp_valid})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule
